// File: rtl/tt_vec_mul_pkg.sv
// Shared types for the SEW-configurable vector multiplier pipeline.
package tt_vec_mul_pkg;

  localparam int VLEN_CFG = 256;
  localparam int TAG_CFG  = 8;
  localparam int ELEM_MAX = VLEN_CFG / 8;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  // Payload carried by every pipeline stage; the product is already final.
  typedef struct packed {
    sew_e                sew;
    logic                hi;
    logic [VLEN_CFG-1:0] result;
    logic [TAG_CFG-1:0]  tag;
  } stage_t;

endpackage

// File: rtl/tt_vec_mul_lane64.sv
// Combinational multiplier for one 64-bit slot: 8x8b, 4x16b, 2x32b or 1x64b
// products with per-operand signedness and low/high half selection.
module tt_vec_mul_lane64
  import tt_vec_mul_pkg::*;
(
  input  logic [1:0]  i_sew,
  input  logic        i_hi,
  input  logic        i_sgn_src1,
  input  logic        i_sgn_src2,
  input  logic [63:0] i_src1,
  input  logic [63:0] i_src2,
  output logic [63:0] o_result
);

  logic [63:0] res_w [4];

  for (genvar w = 0; w < 4; w++) begin : g_width
    localparam int SEW = 8 << w;
    logic [63:0] res;

    for (genvar k = 0; k < 64 / SEW; k++) begin : g_elem
      logic [2*SEW-1:0] ext1;
      logic [2*SEW-1:0] ext2;
      logic [2*SEW-1:0] prod;

      // Extending to 2*SEW makes a plain truncated multiply equal to the exact product.
      assign ext1 = {{SEW{i_sgn_src1 & i_src1[k*SEW+SEW-1]}}, i_src1[k*SEW +: SEW]};
      assign ext2 = {{SEW{i_sgn_src2 & i_src2[k*SEW+SEW-1]}}, i_src2[k*SEW +: SEW]};
      assign prod = ext1 * ext2;
      assign res[k*SEW +: SEW] = i_hi ? prod[2*SEW-1:SEW] : prod[SEW-1:0];
    end

    assign res_w[w] = res;
  end

  // Pick the element-width interpretation requested for this transaction.
  always_comb begin
    o_result = res_w[0];
    case (sew_e'(i_sew))
      SEW8:    o_result = res_w[0];
      SEW16:   o_result = res_w[1];
      SEW32:   o_result = res_w[2];
      SEW64:   o_result = res_w[3];
      default: o_result = res_w[0];
    endcase
  end

endmodule

// File: rtl/tt_vec_mul_pipe.sv
// Pipelined vector integer multiplier with valid/ready on both sides and
// per-stage bubble collapsing. The product is formed in front of s0; later
// stages only carry data so synthesis can retime the multiplier across them.
module tt_vec_mul_pipe
  import tt_vec_mul_pkg::*;
#(
  parameter int VLEN   = VLEN_CFG,
  parameter int STAGES = 2,
  parameter int TAG_W  = TAG_CFG
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_sew,
  input  logic             i_hi,
  input  logic             i_sgn_src1,
  input  logic             i_sgn_src2,
  input  logic [VLEN-1:0]  i_src1,
  input  logic [VLEN-1:0]  i_src2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [VLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int LANES = VLEN / 64;

  logic [VLEN-1:0]   prod;
  stage_t            s0_payload;
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_load;
  logic [STAGES-1:0] stg_in_valid;
  stage_t            stg_data    [STAGES];
  stage_t            stg_in_data [STAGES];
  logic              full_tail;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tt_vec_mul_lane64 u_lane (
      .i_sew      (i_sew),
      .i_hi       (i_hi),
      .i_sgn_src1 (i_sgn_src1),
      .i_sgn_src2 (i_sgn_src2),
      .i_src1     (i_src1[l*64 +: 64]),
      .i_src2     (i_src2[l*64 +: 64]),
      .o_result   (prod[l*64 +: 64])
    );
  end

  assign s0_payload.sew    = sew_e'(i_sew);
  assign s0_payload.hi     = i_hi;
  assign s0_payload.result = prod;
  assign s0_payload.tag    = i_tag;

  assign stg_in_valid[0] = i_valid;
  assign stg_in_data[0]  = s0_payload;

  for (genvar s = 1; s < STAGES; s++) begin : g_chain
    assign stg_in_valid[s] = stg_valid[s-1];
    assign stg_in_data[s]  = stg_data[s-1];
  end

  // A stage may load if downstream drains, or any stage at or after it is empty.
  always_comb begin
    full_tail = 1'b1;
    stg_load  = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      full_tail   = full_tail & stg_valid[s];
      stg_load[s] = i_ready | ~full_tail;
    end
  end

  // Stage registers: advance only on load; data is kept when no valid arrives.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stg_valid <= '0;
      for (int s = 0; s < STAGES; s++) begin
        stg_data[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (stg_load[s]) begin
          stg_valid[s] <= stg_in_valid[s];
          if (stg_in_valid[s]) begin
            stg_data[s] <= stg_in_data[s];
          end
        end
      end
    end
  end

  assign o_ready  = stg_load[0];
  assign o_valid  = stg_valid[STAGES-1];
  assign o_result = stg_data[STAGES-1].result;
  assign o_tag    = stg_data[STAGES-1].tag;

endmodule

// File: tb/tb_tt_vec_mul_pipe.sv
// Self-checking bench for tt_vec_mul_pipe: directed boundary products,
// backpressure, bubble collapse, reset mid-flight and a randomized run
// scored against an arithmetic element-by-element model.
module tb_tt_vec_mul_pipe;

  localparam int VLEN   = 256;
  localparam int STAGES = 2;
  localparam int TAG_W  = 8;

  typedef struct {
    logic [VLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [1:0]      sew;
    bit              hi;
    bit              s1;
    bit              s2;
    logic [VLEN-1:0] a;
    logic [VLEN-1:0] b;
    logic [VLEN-1:0] want;
    string           name;
  } case_t;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [1:0]       i_sew = '0;
  logic             i_hi = 1'b0;
  logic             i_sgn_src1 = 1'b0;
  logic             i_sgn_src2 = 1'b0;
  logic [VLEN-1:0]  i_src1 = '0;
  logic [VLEN-1:0]  i_src2 = '0;
  logic [TAG_W-1:0] i_tag = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [VLEN-1:0]  o_result;
  logic [TAG_W-1:0] o_tag;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t sb[$];

  tt_vec_mul_pipe #(.VLEN(VLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sew      (i_sew),
    .i_hi       (i_hi),
    .i_sgn_src1 (i_sgn_src1),
    .i_sgn_src2 (i_sgn_src2),
    .i_src1     (i_src1),
    .i_src2     (i_src2),
    .i_tag      (i_tag),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_tag      (o_tag)
  );

  always #5 i_clk = ~i_clk;

  // Reference: split into VLEN/SEW elements, extend each, multiply, pick a half.
  function automatic logic [VLEN-1:0] model(input logic [1:0] sew, input bit hi,
                                            input bit s1, input bit s2,
                                            input logic [VLEN-1:0] a,
                                            input logic [VLEN-1:0] b);
    int w;
    logic [127:0] mask, ea, eb, p, r;
    logic [VLEN-1:0] out;
    w = 8 << sew;
    mask = (128'd1 << w) - 128'd1;
    out = '0;
    for (int k = 0; k < VLEN / w; k++) begin
      ea = 128'(a >> (k * w)) & mask;
      eb = 128'(b >> (k * w)) & mask;
      if (s1 && ea[w-1]) ea = ea | ~mask;
      if (s2 && eb[w-1]) eb = eb | ~mask;
      p = ea * eb;
      r = hi ? ((p >> w) & mask) : (p & mask);
      out = out | (VLEN'(r) << (k * w));
    end
    return out;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then let outputs settle.
  task automatic drive(input bit v, input bit rdy, input logic [1:0] sew,
                       input bit hi, input bit s1, input bit s2,
                       input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                       input logic [TAG_W-1:0] tag);
    @(negedge i_clk);
    i_valid = v; i_ready = rdy; i_sew = sew; i_hi = hi;
    i_sgn_src1 = s1; i_sgn_src2 = s2; i_src1 = a; i_src2 = b; i_tag = tag;
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    tests_run++;
    if (o_valid !== 1'b0 || o_result !== '0 || o_tag !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got valid=%b tag=%h result=%h, expected all zero",
               o_valid, o_tag, o_result);
    end
    i_reset_n = 1'b1;
    #1;
    tests_run++;
    if (o_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_fixed_products();
    case_t cs[8];
    int lat;
    cs[0] = '{2'd0, 1'b0, 1'b1, 1'b1, {32{8'hFF}}, {32{8'h02}}, {32{8'hFE}}, "sew8_lo_ss"};
    cs[1] = '{2'd0, 1'b1, 1'b1, 1'b1, {32{8'hFF}}, {32{8'h02}}, {32{8'hFF}}, "sew8_hi_ss"};
    cs[2] = '{2'd0, 1'b1, 1'b0, 1'b0, {32{8'hFF}}, {32{8'h02}}, {32{8'h01}}, "sew8_hi_uu"};
    cs[3] = '{2'd0, 1'b1, 1'b1, 1'b0, {32{8'hFF}}, {32{8'h02}}, {32{8'hFF}}, "sew8_hi_su"};
    cs[4] = '{2'd3, 1'b1, 1'b1, 1'b1, {4{64'h8000_0000_0000_0000}},
              {4{64'h8000_0000_0000_0000}}, {4{64'h4000_0000_0000_0000}}, "sew64_hi_min"};
    cs[5] = '{2'd3, 1'b0, 1'b1, 1'b1, {4{64'h8000_0000_0000_0000}},
              {4{64'h8000_0000_0000_0000}}, '0, "sew64_lo_min"};
    cs[6] = '{2'd1, 1'b0, 1'b1, 1'b1, {16{16'h7FFF}}, {16{16'h7FFF}}, {16{16'h0001}}, "sew16_lo_max"};
    cs[7] = '{2'd2, 1'b1, 1'b0, 1'b0, {8{32'hFFFF_FFFF}}, {8{32'h2}}, {8{32'h1}}, "sew32_hi_uu"};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, cs[i].sew, cs[i].hi, cs[i].s1, cs[i].s2, cs[i].a, cs[i].b, 8'(8'h40 + i));
      lat = 0;
      do begin
        drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        lat++;
      end while (!o_valid && lat < 10);
      tests_run++;
      if (lat != STAGES) begin
        tests_failed++;
        $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", cs[i].name, lat, STAGES);
      end
      tests_run++;
      if (o_result !== cs[i].want || o_tag !== 8'(8'h40 + i)) begin
        tests_failed++;
        $display("[TB] FAIL %s: got tag=%h result=%h expected tag=%h result=%h",
                 cs[i].name, o_tag, o_result, 8'(8'h40 + i), cs[i].want);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [TAG_W-1:0] next_tag;
    logic [VLEN-1:0] a, b, held_res;
    logic [TAG_W-1:0] held_tag;
    logic [1:0] sew;
    bit hi, s1, s2;
    exp_t e;
    int guard;
    sb.delete();
    acc = 0;
    next_tag = 8'h10;
    for (int c = 0; c < 5; c++) begin
      a = rand_vec(); b = rand_vec(); sew = 2'($urandom_range(0, 3));
      hi = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
      drive(1'b1, 1'b0, sew, hi, s1, s2, a, b, next_tag);
      if (c == 2) begin
        held_res = o_result;
        held_tag = o_tag;
      end else if (c > 2) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_result !== held_res || o_tag !== held_tag) begin
          tests_failed++;
          $display("[TB] FAIL stall_stable: got valid=%b tag=%h expected valid=1 tag=%h",
                   o_valid, o_tag, held_tag);
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back('{model(sew, hi, s1, s2, a, b), next_tag});
        acc++;
        next_tag++;
      end
    end
    tests_run++;
    if (acc != 2 || o_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_accepts: got %0d accepts ready=%b expected 2 accepts ready=0",
               acc, o_ready);
    end
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      a = rand_vec(); b = rand_vec(); sew = 2'($urandom_range(0, 3));
      hi = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
      drive(guard < 4, 1'b1, sew, hi, s1, s2, a, b, next_tag);
      tests_run++;
      if (o_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL release_throughput: got valid=%b expected 1 in cycle %0d", o_valid, guard);
      end else begin
        e = sb.pop_front();
        if (o_result !== e.res || o_tag !== e.tag) begin
          tests_failed++;
          $display("[TB] FAIL release_order: got tag=%h result=%h expected tag=%h result=%h",
                   o_tag, o_result, e.tag, e.res);
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back('{model(sew, hi, s1, s2, a, b), next_tag});
        next_tag++;
      end
      guard++;
    end
    tests_run++;
    if (sb.size() != 0 || next_tag != 8'h16) begin
      tests_failed++;
      $display("[TB] FAIL release_drain: got %0d left, next tag %h, expected 0 left, next tag 16",
               sb.size(), next_tag);
    end
  endtask

  task automatic test_bubble_mixed_sew();
    drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, {16{16'h7FFF}}, {16{16'h7FFF}}, 8'hA1);
    tests_run++;
    if (o_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bubble_first_accept: got ready=%b expected 1", o_ready);
    end
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, {8{32'hFFFF_FFFF}}, {8{32'h2}}, 8'hB2);
    tests_run++;
    if (o_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bubble_collapse: got ready=%b expected 1", o_ready);
    end
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tests_run++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_tag !== 8'hA1 || o_result !== {16{16'h0001}}) begin
      tests_failed++;
      $display("[TB] FAIL bubble_first_result: got ready=%b valid=%b tag=%h result=%h expected 0 1 a1 %h",
               o_ready, o_valid, o_tag, o_result, {16{16'h0001}});
    end
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tests_run++;
    if (o_valid !== 1'b1 || o_tag !== 8'hB2 || o_result !== {8{32'h1}}) begin
      tests_failed++;
      $display("[TB] FAIL bubble_second_result: got valid=%b tag=%h result=%h expected 1 b2 %h",
               o_valid, o_tag, o_result, {8{32'h1}});
    end
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bubble_empty: got valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, {32{8'h03}}, {32{8'h05}}, 8'h77);
    drive(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, rand_vec(), rand_vec(), 8'h78);
    @(negedge i_clk);
    i_valid = 1'b0;
    #2;
    i_reset_n = 1'b0;
    #1;
    tests_run++;
    if (o_valid !== 1'b0 || o_result !== '0 || o_tag !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_async: got valid=%b tag=%h result=%h expected all zero",
               o_valid, o_tag, o_result);
    end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tests_run++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_after: got valid=%b ready=%b expected valid=0 ready=1",
                 o_valid, o_ready);
      end
    end
  endtask

  task automatic test_random();
    int sent, cyc;
    bit v, r, hi, s1, s2;
    logic [1:0] sew;
    logic [VLEN-1:0] a, b;
    exp_t e;
    sb.delete();
    sent = 0;
    cyc = 0;
    while ((sent < 40 || sb.size() != 0) && cyc < 3000) begin
      v = (sent < 40) && ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      a = rand_vec(); b = rand_vec(); sew = 2'($urandom_range(0, 3));
      hi = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
      drive(v, r, sew, hi, s1, s2, a, b, 8'(sent));
      if (o_valid && i_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL random_extra: got tag=%h with nothing outstanding", o_tag);
        end else begin
          e = sb.pop_front();
          if (o_result !== e.res || o_tag !== e.tag) begin
            tests_failed++;
            $display("[TB] FAIL random_result: got tag=%h result=%h expected tag=%h result=%h",
                     o_tag, o_result, e.tag, e.res);
          end
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back('{model(sew, hi, s1, s2, a, b), 8'(sent)});
        sent++;
      end
      cyc++;
    end
    tests_run++;
    if (sent != 40 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL random_complete: got %0d sent %0d pending, expected 40 sent 0 pending",
               sent, sb.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fixed_products();
    test_backpressure();
    test_bubble_mixed_sew();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
